conv_result_streamer: RTL

Drains the flattened 6x6x3 convolution result produced by the conv stage and streams it out one byte per handshake over a valid/ready interface. It is the reading end of the conv result bus. It captures the whole `conv_lin` frame on the conv stage's valid rising edge, then serializes 108 bytes in channel/row/column order with position sideband and a last flag. It sits between the conv stage and the downstream pooling/FC or host-readback path.

---
 rtl/conv_result_streamer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/conv_result_streamer.sv
// Captures a CH x ROWS x COLS conv result frame on the rising edge of conv_vld and streams
// it out one byte per valid/ready handshake. Define CONV_STREAM_RELU_EN to zero negative bytes.
module conv_result_streamer #(
    parameter int CH   = 3,
    parameter int ROWS = 6,
    parameter int COLS = 6,
    parameter int DW   = 8,
    localparam int N    = CH * ROWS * COLS,
    localparam int CHW  = (CH   > 1) ? $clog2(CH)   : 1,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int IDXW = (N    > 1) ? $clog2(N)    : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            conv_vld,
    input  logic [N*DW-1:0] conv_lin,
    output logic            in_rdy,
    output logic [DW-1:0]   out_data,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [CHW-1:0]  out_ch,
    output logic [RW-1:0]   out_row,
    output logic [CLW-1:0]  out_col,
    output logic            out_last,
    output logic            frame_done,
    output logic            ovf
);
    typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_conv_vld_q;
    logic [DW-1:0]   r_buf [N];
    logic [DW-1:0]   w_lin_elem [N];
    logic [IDXW-1:0] r_idx;
    logic [CHW-1:0]  r_ch;
    logic [RW-1:0]   r_row;
    logic [CLW-1:0]  r_col;
    logic            r_last;
    logic            r_frame_done;
    logic            r_ovf;
    logic [DW-1:0]   r_out_data;

    logic            w_start;
    logic            w_capture;
    logic            w_xfer;
    logic            w_last_xfer;
    logic [IDXW-1:0] w_idx_next;
    logic [CHW-1:0]  w_ch_next;
    logic [RW-1:0]   w_row_next;
    logic [CLW-1:0]  w_col_next;
    logic            w_last_next;

    function automatic logic [DW-1:0] f_shape(input logic [DW-1:0] b);
`ifdef CONV_STREAM_RELU_EN
        return b[DW-1] ? '0 : b;
`else
        return b;
`endif
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign w_lin_elem[gi] = conv_lin[gi*DW +: DW];
        end
    endgenerate

    assign w_start     = conv_vld & ~r_conv_vld_q;
    assign w_capture   = (r_state == ST_IDLE) & w_start;
    assign w_xfer      = (r_state == ST_SEND) & out_rdy;
    assign w_last_xfer = w_xfer & r_last;

    always_comb begin
        w_idx_next = r_idx + IDXW'(1);
        w_col_next = r_col + CLW'(1);
        w_row_next = r_row;
        w_ch_next  = r_ch;
        if (r_col == CLW'(COLS - 1)) begin
            w_col_next = '0;
            w_row_next = r_row + RW'(1);
            if (r_row == RW'(ROWS - 1)) begin
                w_row_next = '0;
                w_ch_next  = r_ch + CHW'(1);
            end
        end
        w_last_next = (w_idx_next == IDXW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start)     w_state_next = ST_SEND;
            ST_SEND: if (w_last_xfer) w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
    end

    // The buffer is only written while idle, so a frame arriving mid-stream cannot corrupt it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < N; i++) r_buf[i] <= w_lin_elem[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_conv_vld_q <= 1'b0;
            r_idx        <= '0;
            r_ch         <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
            r_ovf        <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_conv_vld_q <= conv_vld;
            r_frame_done <= w_last_xfer;
            if (w_start && (r_state == ST_SEND)) begin
                r_ovf <= 1'b1;
            end
            // Element 0 comes straight from the input bus since the buffer is loading this edge.
            if (w_capture) begin
                r_idx      <= '0;
                r_ch       <= '0;
                r_row      <= '0;
                r_col      <= '0;
                r_last     <= (N == 1);
                r_out_data <= f_shape(w_lin_elem[0]);
            end else if (w_last_xfer) begin
                r_idx      <= '0;
                r_ch       <= '0;
                r_row      <= '0;
                r_col      <= '0;
                r_last     <= 1'b0;
                r_out_data <= '0;
            end else if (w_xfer) begin
                r_idx      <= w_idx_next;
                r_ch       <= w_ch_next;
                r_row      <= w_row_next;
                r_col      <= w_col_next;
                r_last     <= w_last_next;
                r_out_data <= f_shape(r_buf[w_idx_next]);
            end
        end
    end

    assign in_rdy     = (r_state == ST_IDLE);
    assign out_vld    = (r_state == ST_SEND);
    assign out_data   = r_out_data;
    assign out_ch     = r_ch;
    assign out_row    = r_row;
    assign out_col    = r_col;
    assign out_last   = r_last;
    assign frame_done = r_frame_done;
    assign ovf        = r_ovf;
endmodule
